mmul_parallel_mac_engine: RTL and testbench
===========================================

Name: mmul_parallel_mac_engine

Overview:
- Datapath engine of the MMUL_PARALLEL HWPE; sits directly downstream of the HWPE control FSM.
- Consumes the FSM's engine controls (start, clear, enable, simple_mul, shift, len) plus the A and B source streams.
- Produces the C sink stream and the engine flags (cnt, ready, acc_valid) the FSM uses for sequencing and termination.
- Modes: element-wise multiply (one C beat per A/B pair) or dot-product accumulate (one C beat per job).

Parameters:
- DATA_W, 32, width of A/B/C stream data (signed two's complement).
- CNT_W, 16, width of len and cnt.
- SHIFT_W, 7, width of the shift control.
- Derived, not overridable: PROD_W = 2*DATA_W; ACC_W = PROD_W + CNT_W (accumulator cannot overflow).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- clear_i  in  1  synchronous soft clear from HWPE control
- ctrl_start_i  in  1  job start pulse
- ctrl_clear_i  in  1  synchronous engine clear
- ctrl_enable_i  in  1  global advance enable; 0 freezes the block
- ctrl_simple_mul_i  in  1  1 = element-wise, 0 = accumulate
- ctrl_shift_i  in  SHIFT_W  arithmetic right shift applied to results
- ctrl_len_i  in  CNT_W  number of A/B pairs in the job
- a_valid_i / a_ready_o / a_data_i  in/out/in  1/1/DATA_W  A stream
- b_valid_i / b_ready_o / b_data_i  in/out/in  1/1/DATA_W  B stream
- c_valid_o / c_ready_i / c_data_o  out/in/out  1/1/DATA_W  C stream
- flag_cnt_o  out  CNT_W  pairs retired in current job
- flag_ready_o  out  1  engine idle, accepts start
- flag_acc_valid_o  out  1  one-cycle pulse when accumulated result enters C register

Behaviour:
- Reset (rst_i=1, async): state IDLE; all stage valids 0; acc 0; cnt 0. Outputs: a_ready_o=0, b_ready_o=0, c_valid_o=0, c_data_o=0, flag_cnt_o=0, flag_ready_o=1, flag_acc_valid_o=0.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - flag_ready_o=1.
  - On ctrl_start_i & ctrl_enable_i: latch len/simple_mul/shift, cnt:=0, acc:=0, go to RUN.
  - If latched len==0: go to IDLE instead; no handshakes, no C beat, no acc_valid pulse.
- RUN:
  - Pair accepted when a_valid_i & b_valid_i & stage1 free (empty or advancing).
  - a_ready_o = b_ready_o = that free condition & ctrl_enable_i & (accepted < len). Both ready together (join); no one-sided consumption.
  - Stage1 registers signed product (PROD_W).
  - Stage2, simple mode: result = sat(product >>> shift) into C register; requires C register empty or c_ready_i.
  - Stage2, accumulate mode: acc += sign-extended product, unconditional. On the len-th product, sat((acc+product) >>> shift) into C register and pulse flag_acc_valid_o.
  - cnt increments once per product retired by stage2.
  - Go to FLUSH when cnt reaches len.
- FLUSH: wait for final C beat accepted (c_valid_o & c_ready_i), then go to IDLE.
- Latency (simple mode): pair accepted in cycle t gives c_valid_o=1 in cycle t+2. Full throughput of 1 pair/cycle when c_ready_i=1.
- Backpressure:
  - c_valid_o holds and c_data_o stays stable until accepted.
  - A full C register with c_ready_i=0 stalls stage1; a_ready_o/b_ready_o drop the same cycle. No data loss or duplication.
- Saturation: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. If shift >= ACC_W, result is sign-fill (0 or -1).
- ctrl_enable_i=0: nothing advances; readies 0; C register and flags hold.
- ctrl_clear_i or clear_i (any state): next cycle IDLE; pipe flushed; c_valid_o=0; acc=0; cnt=0. Clear has priority over a simultaneous start.
- ctrl_start_i outside IDLE is ignored.

Optional Feature:
- MMUL_PARALLEL_ROUND_EN defined: round-half-up before the shift; adds 1<<(shift-1) when shift>0, in ACC_W width, before saturation.
- Undefined: plain arithmetic shift (floor).

Test Plan:
- Simple mode, len=4, shift=0, A={1,2,3,-4}, B={5,6,7,8}, c_ready_i=1 -> C={5,12,21,-32}; first C two cycles after first accept; flag_cnt_o ends at 4; returns to IDLE.
- Accumulate mode, len=3, shift=1, A={10,20,30}, B={1,1,1} -> single C beat 30; flag_acc_valid_o high exactly one cycle; flag_cnt_o=3.
- Saturation, simple mode, shift=0: A=B=0x7FFFFFFF -> C=0x7FFFFFFF. A=0x7FFFFFFF, B=0x80000000 -> C=0x80000000.
- Backpressure: len=8, c_ready_i=0 for 5 cycles after first C valid -> readies drop within one cycle; all 8 results delivered in order, none lost or duplicated.
- len=0 start -> no A/B handshake, no C beat, flag_ready_o=1 again within 2 cycles. Start while RUN -> ignored.
- Clear after 2 of 4 pairs -> next cycle IDLE, cnt=0, c_valid_o=0. Product 7 with shift=1 -> C=4 with MMUL_PARALLEL_ROUND_EN, 3 without.

Source files
------------

// File: rtl/mmul_parallel_mac_engine_if.sv
// A/B source and C sink stream bundle of the MMUL_PARALLEL engine.
// The slave modport is the engine side and the master modport is the stream environment.
interface mmul_parallel_mac_engine_if #(
  parameter int DATA_W = 32
);
  logic                     a_valid_i;
  logic                     a_ready_o;
  logic signed [DATA_W-1:0] a_data_i;
  logic                     b_valid_i;
  logic                     b_ready_o;
  logic signed [DATA_W-1:0] b_data_i;
  logic                     c_valid_o;
  logic                     c_ready_i;
  logic signed [DATA_W-1:0] c_data_o;

  modport slave (
    input  a_valid_i, a_data_i, b_valid_i, b_data_i, c_ready_i,
    output a_ready_o, b_ready_o, c_valid_o, c_data_o
  );

  modport master (
    output a_valid_i, a_data_i, b_valid_i, b_data_i, c_ready_i,
    input  a_ready_o, b_ready_o, c_valid_o, c_data_o
  );
endinterface

// File: rtl/mmul_parallel_mac_engine.sv
// MMUL_PARALLEL datapath engine: joined A/B multiply, then element-wise or accumulated shift/saturate into C.
// Define MMUL_PARALLEL_ROUND_EN to get round-half-up before the shift; otherwise the shift floors.
module mmul_parallel_mac_engine #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int SHIFT_W = 7
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               ctrl_start_i,
  input  logic               ctrl_clear_i,
  input  logic               ctrl_enable_i,
  input  logic               ctrl_simple_mul_i,
  input  logic [SHIFT_W-1:0] ctrl_shift_i,
  input  logic [CNT_W-1:0]   ctrl_len_i,
  mmul_parallel_mac_engine_if.slave s_if,
  output logic [CNT_W-1:0]   flag_cnt_o,
  output logic               flag_ready_o,
  output logic               flag_acc_valid_o
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + CNT_W;

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  // One extra bit of headroom keeps the rounding add from wrapping at the largest shifts.
  function automatic logic signed [DATA_W-1:0] f_shift_sat(
    input logic signed [ACC_W-1:0]   v,
    input logic        [SHIFT_W-1:0] sh
  );
    logic signed [ACC_W:0] ext;
    ext = (ACC_W+1)'(v);
    if (32'(sh) >= ACC_W) begin
      return v[ACC_W-1] ? '1 : '0;
    end
`ifdef MMUL_PARALLEL_ROUND_EN
    if (sh != '0) begin
      ext = ext + ((ACC_W+1)'(1) <<< (sh - SHIFT_W'(1)));
    end
`endif
    ext = ext >>> sh;
    if (ext > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end
    if (ext < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end
    return ext[DATA_W-1:0];
  endfunction

  state_t                     r_state;
  logic [CNT_W-1:0]           r_len;
  logic                       r_simple;
  logic [SHIFT_W-1:0]         r_shift;
  logic [CNT_W-1:0]           r_taken;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_vld_p1;
  logic signed [PROD_W-1:0]   r_prod_p1;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_vld_p2;
  logic signed [DATA_W-1:0]   r_data_p2;
  logic                       r_acc_vld_p2;

  logic                       w_clear;
  logic [CNT_W-1:0]           w_cnt_nxt;
  logic                       w_last;
  logic                       w_c_free;
  logic                       w_s2_go;
  logic                       w_s1_free;
  logic                       w_ab_ready;
  logic                       w_accept;
  logic                       w_c_pop;
  logic                       w_c_load;
  logic signed [PROD_W-1:0]   w_a_ext;
  logic signed [PROD_W-1:0]   w_b_ext;
  logic signed [ACC_W-1:0]    w_acc_sum;
  logic signed [DATA_W-1:0]   w_result;

  assign w_clear    = clear_i | ctrl_clear_i;
  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  assign w_last     = (w_cnt_nxt == r_len);
  assign w_c_free   = ~r_vld_p2 | s_if.c_ready_i;
  // Accumulation never waits on C except for the final product, which must land in the C register.
  assign w_s2_go    = ctrl_enable_i & r_vld_p1 & ((~r_simple & ~w_last) | w_c_free);
  assign w_s1_free  = ~r_vld_p1 | w_s2_go;
  assign w_ab_ready = (r_state == S_RUN) & w_s1_free & ctrl_enable_i & (r_taken < r_len);
  assign w_accept   = w_ab_ready & s_if.a_valid_i & s_if.b_valid_i;
  assign w_c_pop    = ctrl_enable_i & r_vld_p2 & s_if.c_ready_i;
  assign w_c_load   = w_s2_go & (r_simple | w_last);

  assign w_a_ext    = PROD_W'(s_if.a_data_i);
  assign w_b_ext    = PROD_W'(s_if.b_data_i);
  assign w_acc_sum  = r_acc + ACC_W'(r_prod_p1);
  assign w_result   = f_shift_sat(r_simple ? ACC_W'(r_prod_p1) : w_acc_sum, r_shift);

  assign s_if.a_ready_o = w_ab_ready;
  assign s_if.b_ready_o = w_ab_ready;
  assign s_if.c_valid_o = r_vld_p2;
  assign s_if.c_data_o  = r_data_p2;
  assign flag_cnt_o       = r_cnt;
  assign flag_ready_o     = (r_state == S_IDLE);
  assign flag_acc_valid_o = r_acc_vld_p2;

  // Stage 1: signed product of the joined A/B pair
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_prod_p1 <= w_a_ext * w_b_ext;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_simple     <= 1'b0;
      r_shift      <= '0;
      r_taken      <= '0;
      r_cnt        <= '0;
      r_vld_p1     <= 1'b0;
      r_acc        <= '0;
      r_vld_p2     <= 1'b0;
      r_data_p2    <= '0;
      r_acc_vld_p2 <= 1'b0;
    end else if (w_clear) begin
      r_state      <= S_IDLE;
      r_taken      <= '0;
      r_cnt        <= '0;
      r_vld_p1     <= 1'b0;
      r_acc        <= '0;
      r_vld_p2     <= 1'b0;
      r_acc_vld_p2 <= 1'b0;
    end else begin
      r_acc_vld_p2 <= w_c_load & ~r_simple;
      case (r_state)
        S_IDLE: begin
          if (ctrl_start_i & ctrl_enable_i) begin
            r_len    <= ctrl_len_i;
            r_simple <= ctrl_simple_mul_i;
            r_shift  <= ctrl_shift_i;
            r_taken  <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_state  <= (ctrl_len_i == '0) ? S_IDLE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_s2_go & w_last) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_c_pop | ~r_vld_p2) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_accept) begin
        r_taken  <= r_taken + CNT_W'(1);
        r_vld_p1 <= 1'b1;
      end else if (w_s2_go) begin
        r_vld_p1 <= 1'b0;
      end

      // Stage 2: retire product into the accumulator and/or the C register
      if (w_s2_go) begin
        r_cnt <= w_cnt_nxt;
        if (!r_simple) begin
          r_acc <= w_acc_sum;
        end
      end

      if (w_c_load) begin
        r_vld_p2  <= 1'b1;
        r_data_p2 <= w_result;
      end else if (w_c_pop) begin
        r_vld_p2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mmul_parallel_mac_engine.sv
// Directed self-checking bench for mmul_parallel_mac_engine (simple, accumulate, saturation,
// backpressure, zero-length, clear and shift/rounding behaviour).
module tb_mmul_parallel_mac_engine;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int SHIFT_W = 7;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               clear_i;
  logic               ctrl_start_i;
  logic               ctrl_clear_i;
  logic               ctrl_enable_i;
  logic               ctrl_simple_mul_i;
  logic [SHIFT_W-1:0] ctrl_shift_i;
  logic [CNT_W-1:0]   ctrl_len_i;
  logic [CNT_W-1:0]   flag_cnt_o;
  logic               flag_ready_o;
  logic               flag_acc_valid_o;

  mmul_parallel_mac_engine_if #(.DATA_W(DATA_W)) s_if();

  mmul_parallel_mac_engine #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SHIFT_W(SHIFT_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .clear_i           (clear_i),
    .ctrl_start_i      (ctrl_start_i),
    .ctrl_clear_i      (ctrl_clear_i),
    .ctrl_enable_i     (ctrl_enable_i),
    .ctrl_simple_mul_i (ctrl_simple_mul_i),
    .ctrl_shift_i      (ctrl_shift_i),
    .ctrl_len_i        (ctrl_len_i),
    .s_if              (s_if),
    .flag_cnt_o        (flag_cnt_o),
    .flag_ready_o      (flag_ready_o),
    .flag_acc_valid_o  (flag_acc_valid_o)
  );

  always #5 clk = ~clk;

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [31:0] c_q[$];
  int          va[0:15];
  int          vb[0:15];
  int          ev[0:15];
  int          n_accv;
  int          job_lat;
  logic        job_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_beats(input string tag, input int n);
    chk({tag, "_nbeats"}, c_q.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_beat%0d", tag, i), (i < c_q.size()) ? c_q[i] : 32'h0badbad0, ev[i]);
    end
  endtask

  // Runs one job: start pulse, stream va/vb, optional C backpressure and mid-job start attempt.
  task automatic run_job(input logic simple, input int sh, input int len, input int bp,
                         input logic mid_start);
    int   idx;
    int   bp_left;
    int   first_a;
    int   first_cv;
    logic fire;
    c_q.delete();
    n_accv = 0; job_done = 1'b0; bp_left = 0; first_a = -1; first_cv = -1; idx = 0;
    @(posedge clk); #1;
    ctrl_start_i = 1'b1; ctrl_simple_mul_i = simple;
    ctrl_shift_i = SHIFT_W'(sh); ctrl_len_i = CNT_W'(len);
    @(posedge clk); #1;
    ctrl_start_i = 1'b0;
    s_if.a_valid_i = 1'b1; s_if.b_valid_i = 1'b1;
    s_if.a_data_i = va[0]; s_if.b_data_i = vb[0];
    s_if.c_ready_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_if.c_valid_o && s_if.c_ready_i) c_q.push_back(s_if.c_data_o);
      if (flag_acc_valid_o) n_accv++;
      fire = s_if.a_valid_i && s_if.a_ready_o;
      if (fire && first_a < 0) first_a = k;
      if (s_if.c_valid_o && first_cv < 0) begin
        first_cv = k;
        if (bp > 0) bp_left = bp;
      end
      if (bp > 0 && !s_if.c_ready_i)
        chk("bp_ready_drop", {30'b0, s_if.a_ready_o, s_if.b_ready_o}, 32'h0);
      if (flag_ready_o) begin
        job_done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (fire) begin
        idx++;
        if (idx < len) begin
          s_if.a_data_i = va[idx]; s_if.b_data_i = vb[idx];
        end else begin
          s_if.a_valid_i = 1'b0; s_if.b_valid_i = 1'b0;
        end
      end
      if (bp_left > 0) begin
        s_if.c_ready_i = 1'b0;
        bp_left--;
      end else begin
        s_if.c_ready_i = 1'b1;
      end
      if (mid_start && k == 3) begin
        ctrl_start_i = 1'b1; ctrl_len_i = CNT_W'(2); ctrl_simple_mul_i = 1'b0;
      end else begin
        ctrl_start_i = 1'b0;
      end
    end
    s_if.a_valid_i = 1'b0; s_if.b_valid_i = 1'b0; ctrl_start_i = 1'b0;
    job_lat = first_cv - first_a;
    chk("job_done", {31'b0, job_done}, 32'h1);
  endtask

  initial begin
    int fires;
    rst_i = 1'b1; clear_i = 1'b0; ctrl_start_i = 1'b0; ctrl_clear_i = 1'b0;
    ctrl_enable_i = 1'b1; ctrl_simple_mul_i = 1'b1; ctrl_shift_i = '0; ctrl_len_i = '0;
    s_if.a_valid_i = 1'b0; s_if.b_valid_i = 1'b0; s_if.a_data_i = '0; s_if.b_data_i = '0;
    s_if.c_ready_i = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_a_ready", {31'b0, s_if.a_ready_o}, 32'h0);
    chk("rst_b_ready", {31'b0, s_if.b_ready_o}, 32'h0);
    chk("rst_c_valid", {31'b0, s_if.c_valid_o}, 32'h0);
    chk("rst_c_data", s_if.c_data_o, 32'h0);
    chk("rst_cnt", {16'b0, flag_cnt_o}, 32'h0);
    chk("rst_flag_ready", {31'b0, flag_ready_o}, 32'h1);
    chk("rst_acc_valid", {31'b0, flag_acc_valid_o}, 32'h0);
    @(posedge clk); #1; rst_i = 1'b0;

    // Simple mode, len 4
    va[0:3] = '{1, 2, 3, -4}; vb[0:3] = '{5, 6, 7, 8}; ev[0:3] = '{5, 12, 21, -32};
    run_job(1'b1, 0, 4, 0, 1'b0);
    check_beats("simple", 4);
    chk("simple_latency", job_lat, 2);
    chk("simple_cnt", {16'b0, flag_cnt_o}, 32'd4);
    chk("simple_idle", {31'b0, flag_ready_o}, 32'h1);

    // Accumulate mode, len 3, shift 1
    va[0:2] = '{10, 20, 30}; vb[0:2] = '{1, 1, 1}; ev[0] = 30;
    run_job(1'b0, 1, 3, 0, 1'b0);
    check_beats("accum", 1);
    chk("accum_accv_pulses", n_accv, 1);
    chk("accum_cnt", {16'b0, flag_cnt_o}, 32'd3);

    // Saturation
    va[0:1] = '{32'h7FFFFFFF, 32'h7FFFFFFF}; vb[0:1] = '{32'h7FFFFFFF, 32'h80000000};
    ev[0:1] = '{32'h7FFFFFFF, 32'h80000000};
    run_job(1'b1, 0, 2, 0, 1'b0);
    check_beats("sat", 2);

    // Backpressure with a start attempt while running
    va[0:7] = '{1, -2, 3, -4, 5, -6, 7, -8};
    vb[0:7] = '{10, 10, 10, 10, 10, 10, 10, 10};
    ev[0:7] = '{10, -20, 30, -40, 50, -60, 70, -80};
    run_job(1'b1, 0, 8, 5, 1'b1);
    check_beats("bp", 8);
    chk("bp_cnt", {16'b0, flag_cnt_o}, 32'd8);

    // Shift at or beyond accumulator width gives sign fill
    va[0:1] = '{-5, 5}; vb[0:1] = '{1, 1}; ev[0:1] = '{-1, 0};
    run_job(1'b1, 100, 2, 0, 1'b0);
    check_beats("bigshift", 2);

    // Rounding of product 7 shifted by 1
    va[0] = 7; vb[0] = 1;
`ifdef MMUL_PARALLEL_ROUND_EN
    ev[0] = 4;
`else
    ev[0] = 3;
`endif
    run_job(1'b1, 1, 1, 0, 1'b0);
    check_beats("round", 1);

    // Zero-length job
    @(posedge clk); #1;
    ctrl_start_i = 1'b1; ctrl_len_i = '0; ctrl_simple_mul_i = 1'b1;
    s_if.a_valid_i = 1'b1; s_if.b_valid_i = 1'b1;
    @(posedge clk); #1; ctrl_start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("len0_no_ready", {31'b0, s_if.a_ready_o}, 32'h0);
      chk("len0_no_c", {31'b0, s_if.c_valid_o}, 32'h0);
      chk("len0_flag_ready", {31'b0, flag_ready_o}, 32'h1);
    end
    s_if.a_valid_i = 1'b0; s_if.b_valid_i = 1'b0;

    // Clear after 2 of 4 pairs
    va[0:3] = '{1, 2, 3, 4}; vb[0:3] = '{1, 1, 1, 1};
    @(posedge clk); #1;
    ctrl_start_i = 1'b1; ctrl_len_i = CNT_W'(4); ctrl_simple_mul_i = 1'b1; ctrl_shift_i = '0;
    @(posedge clk); #1;
    ctrl_start_i = 1'b0; s_if.a_valid_i = 1'b1; s_if.b_valid_i = 1'b1;
    s_if.a_data_i = va[0]; s_if.b_data_i = vb[0];
    fires = 0;
    for (int k = 0; k < 20 && fires < 2; k++) begin
      @(negedge clk);
      if (s_if.a_valid_i && s_if.a_ready_o) fires++;
      @(posedge clk); #1;
      s_if.a_data_i = va[fires]; s_if.b_data_i = vb[fires];
    end
    chk("clr_pairs_taken", fires, 2);
    s_if.a_valid_i = 1'b0; s_if.b_valid_i = 1'b0; ctrl_clear_i = 1'b1;
    @(posedge clk); #1; ctrl_clear_i = 1'b0;
    @(negedge clk);
    chk("clr_idle", {31'b0, flag_ready_o}, 32'h1);
    chk("clr_cnt", {16'b0, flag_cnt_o}, 32'h0);
    chk("clr_c_valid", {31'b0, s_if.c_valid_o}, 32'h0);

    // Clear beats a simultaneous start
    @(posedge clk); #1;
    clear_i = 1'b1; ctrl_start_i = 1'b1; ctrl_len_i = CNT_W'(4);
    @(posedge clk); #1; clear_i = 1'b0; ctrl_start_i = 1'b0;
    @(negedge clk);
    chk("clr_prio_idle", {31'b0, flag_ready_o}, 32'h1);
    chk("clr_prio_no_ready", {31'b0, s_if.a_ready_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
